// File: rtl/summing_tree_pkg.sv
// Shared definitions for the summing tree and the arbiter that feeds it:
// default geometry of a transaction and the arbiter's FSM state encoding.
package summing_tree_pkg;

    localparam int NUM_INPUTS = 8;
    localparam int DATA_WIDTH = 8;
    localparam int SUM_W      = DATA_WIDTH + $clog2(NUM_INPUTS);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        STREAM   = 2'd1,
        WAIT_SUM = 2'd2,
        DELIVER  = 2'd3
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin winner select: scans the request vector starting at the
// pointer position and returns the index of the first active requester.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    ptr_i,
    output logic [ID_W-1:0]    grant_o,
    output logic               valid_o
);

    int cand;

    // Walk the requesters in priority order beginning at the pointer and keep the first hit
    always_comb begin
        grant_o = '0;
        valid_o = 1'b0;
        cand    = 0;
        for (int off = 0; off < NUM_REQ; off++) begin
            cand = (int'(ptr_i) + off) % NUM_REQ;
            if (!valid_o && req_i[cand]) begin
                valid_o = 1'b1;
                grant_o = ID_W'(cand);
            end
        end
    end

endmodule

// File: rtl/sum_tree_arbiter.sv
// Shares one summing tree between several requesters. A requester is granted
// for a whole transaction of NUM_INPUTS beats, the tree result is captured and
// held for the consumer, and the round-robin pointer then moves past the owner.
module sum_tree_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int NUM_INPUTS = summing_tree_pkg::NUM_INPUTS,
    parameter int DATA_WIDTH = summing_tree_pkg::DATA_WIDTH
) (
    input  logic                                       clk,
    input  logic                                       rst_n,
    input  logic [NUM_REQ-1:0]                         req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]              req_data,
    output logic [NUM_REQ-1:0]                         req_ready,
    output logic                                       tree_valid,
    output logic [DATA_WIDTH-1:0]                      tree_data,
    input  logic                                       tree_ready,
    input  logic [DATA_WIDTH+$clog2(NUM_INPUTS)-1:0]   tree_sum,
    input  logic                                       tree_sum_valid,
    output logic                                       res_valid,
    output logic [DATA_WIDTH+$clog2(NUM_INPUTS)-1:0]   res_sum,
    output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] res_id,
    input  logic                                       res_ready,
    output logic                                       busy,
    output logic                                       err
);

    import summing_tree_pkg::*;

    localparam int SUM_WIDTH = DATA_WIDTH + $clog2(NUM_INPUTS);
    localparam int ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W     = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NUM_INPUTS - 1);
    localparam logic [ID_W-1:0]  LAST_REQ  = ID_W'(NUM_REQ - 1);

    state_t                 state_q, state_d;
    logic [ID_W-1:0]        grant_q, grant_d;
    logic [ID_W-1:0]        rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]       beat_cnt_q, beat_cnt_d;
    logic                   res_valid_q, res_valid_d;
    logic [SUM_WIDTH-1:0]   res_sum_q, res_sum_d;
    logic [ID_W-1:0]        res_id_q, res_id_d;
    logic                   busy_q, busy_d;
    logic                   err_q, err_d;

    logic [ID_W-1:0]        arb_grant;
    logic                   arb_valid;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_arbiter (
        .req_i   (req_valid),
        .ptr_i   (rr_ptr_q),
        .grant_o (arb_grant),
        .valid_o (arb_valid)
    );

    // State register; reset discards any transaction in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            rr_ptr_q    <= '0;
            beat_cnt_q  <= '0;
            res_valid_q <= 1'b0;
            res_sum_q   <= '0;
            res_id_q    <= '0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rr_ptr_q    <= rr_ptr_d;
            beat_cnt_q  <= beat_cnt_d;
            res_valid_q <= res_valid_d;
            res_sum_q   <= res_sum_d;
            res_id_q    <= res_id_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
        end
    end

    // Next-state logic plus the only combinational outputs: the beat path from granted requester to tree
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rr_ptr_d    = rr_ptr_q;
        beat_cnt_d  = beat_cnt_q;
        res_valid_d = res_valid_q;
        res_sum_d   = res_sum_q;
        res_id_d    = res_id_q;
        err_d       = err_q;
        req_ready   = '0;
        tree_valid  = 1'b0;
        tree_data   = '0;

        if (tree_sum_valid && (state_q != WAIT_SUM)) begin
            err_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    grant_d = arb_grant;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                tree_valid         = req_valid[grant_q];
                tree_data          = req_data[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
                req_ready[grant_q] = tree_ready;
                if (req_valid[grant_q] && tree_ready) begin
                    if (beat_cnt_q == LAST_BEAT) begin
                        beat_cnt_d = '0;
                        state_d    = WAIT_SUM;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end
            end
            WAIT_SUM: begin
                if (tree_sum_valid) begin
                    res_sum_d   = tree_sum;
                    res_id_d    = grant_q;
                    res_valid_d = 1'b1;
                    state_d     = DELIVER;
                end
            end
            DELIVER: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    rr_ptr_d    = (grant_q == LAST_REQ) ? '0 : grant_q + 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    assign res_valid = res_valid_q;
    assign res_sum   = res_sum_q;
    assign res_id    = res_id_q;
    assign busy      = busy_q;
    assign err       = err_q;

endmodule

// File: tb/tb_sum_tree_arbiter.sv
// Bench for sum_tree_arbiter: per-requester beat drivers, a behavioural summing
// tree, and a queue of expected (owner, sum) results filled when stimulus is queued.
module tb_sum_tree_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 8;
    localparam int SW   = 11;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ*DW-1:0] req_data = '0;
    logic [NREQ-1:0]   req_ready;
    logic              tree_valid;
    logic [DW-1:0]     tree_data;
    logic              tree_ready = 1'b1;
    logic [SW-1:0]     tree_sum = '0;
    logic              tree_sum_valid;
    logic              res_valid;
    logic [SW-1:0]     res_sum;
    logic [1:0]        res_id;
    logic              res_ready = 1'b1;
    logic              busy;
    logic              err;

    logic              modelSumValid = 1'b0;
    logic              spurSumValid = 1'b0;
    logic              flushReq = 1'b0;

    int errors = 0;
    int checks = 0;
    int expId[$];
    int expSum[$];

    logic [DW-1:0]     beatMem [NREQ][64];
    int                wrPtr [NREQ] = '{default: 0};
    int                rdPtr [NREQ] = '{default: 0};
    int                gapLeft [NREQ] = '{default: 0};
    int                gapMin [NREQ] = '{default: 0};
    int                gapMax [NREQ] = '{default: 0};
    logic [NREQ-1:0]   acc = '0;

    int                mCnt = 0;
    int                mDelay = 0;
    logic [SW-1:0]     mAcc = '0;

    assign tree_sum_valid = modelSumValid | spurSumValid;

    always #5 clk = ~clk;

    sum_tree_arbiter #(
        .NUM_REQ    (NREQ),
        .NUM_INPUTS (8),
        .DATA_WIDTH (DW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_data       (req_data),
        .req_ready      (req_ready),
        .tree_valid     (tree_valid),
        .tree_data      (tree_data),
        .tree_ready     (tree_ready),
        .tree_sum       (tree_sum),
        .tree_sum_valid (tree_sum_valid),
        .res_valid      (res_valid),
        .res_sum        (res_sum),
        .res_id         (res_id),
        .res_ready      (res_ready),
        .busy           (busy),
        .err            (err)
    );

    // Record which requesters had a beat accepted on this edge
    always @(posedge clk) begin
        acc <= req_valid & req_ready;
    end

    // Requester drivers: advance past accepted beats, insert gaps, present the next queued beat
    always @(negedge clk) begin
        for (int i = 0; i < NREQ; i++) begin
            if (flushReq) begin
                rdPtr[i]   = wrPtr[i];
                gapLeft[i] = 0;
            end else if (acc[i]) begin
                rdPtr[i]   = rdPtr[i] + 1;
                gapLeft[i] = int'($urandom_range(gapMax[i], gapMin[i]));
            end
            if (gapLeft[i] > 0) begin
                req_valid[i] = 1'b0;
                gapLeft[i]   = gapLeft[i] - 1;
            end else if (rdPtr[i] != wrPtr[i]) begin
                req_valid[i]           = 1'b1;
                req_data[i*DW +: DW]   = beatMem[i][rdPtr[i] % 64];
            end else begin
                req_valid[i]           = 1'b0;
                req_data[i*DW +: DW]   = '0;
            end
        end
    end

    // Behavioural summing tree: accumulates 8 beats, returns the sum a few cycles later
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mCnt          <= 0;
            mDelay        <= 0;
            mAcc          <= '0;
            modelSumValid <= 1'b0;
            tree_sum      <= '0;
        end else begin
            modelSumValid <= 1'b0;
            if (mDelay > 0) begin
                if (mDelay == 1) begin
                    modelSumValid <= 1'b1;
                    tree_sum      <= mAcc;
                    mAcc          <= '0;
                end
                mDelay <= mDelay - 1;
            end else if (tree_valid && tree_ready) begin
                mAcc <= mAcc + SW'(tree_data);
                if (mCnt == 7) begin
                    mCnt   <= 0;
                    mDelay <= 2;
                end else begin
                    mCnt <= mCnt + 1;
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    // Queue beats base, base+10, ... base+70 for one requester and push the expected result
    task automatic queueTxn(input int id, input int base, input int gmin, input int gmax);
        gapMin[id] = gmin;
        gapMax[id] = gmax;
        for (int k = 0; k < 8; k++) begin
            beatMem[id][wrPtr[id] % 64] = DW'(base + 10 * k);
            wrPtr[id] = wrPtr[id] + 1;
        end
        expId.push_back(id);
        expSum.push_back(8 * base + 280);
    endtask

    task automatic applyReset();
        rst_n    = 1'b0;
        flushReq = 1'b1;
        repeat (2) tick();
        rst_n    = 1'b1;
        flushReq = 1'b0;
        tick();
    endtask

    // Wait (bounded) for a result, compare against the scoreboard head, then let the handshake complete
    task automatic waitResult(input string name, input int budget);
        int n;
        int eid;
        int esum;
        n = 0;
        while (res_valid !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (res_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL %s timeout: res_valid=%b after %0d cycles, required 1", name, res_valid, n);
        end else if (expId.size() == 0) begin
            errors++;
            $display("[TB] FAIL %s unexpected result id=%0d sum=%0d, required none", name, res_id, res_sum);
        end else begin
            eid  = expId.pop_front();
            esum = expSum.pop_front();
            if (res_id !== 2'(eid)) begin
                errors++;
                $display("[TB] FAIL %s res_id got=%0d required=%0d", name, res_id, eid);
            end
            checks++;
            if (res_sum !== SW'(esum)) begin
                errors++;
                $display("[TB] FAIL %s res_sum got=%0d required=%0d", name, res_sum, esum);
            end
            tick();
        end
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        flushReq = 1'b1;
        #1;
        checks++;
        if ({req_ready, tree_valid, tree_data, res_valid, res_sum, res_id, busy, err} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_outputs got=%h required=0",
                     {req_ready, tree_valid, tree_data, res_valid, res_sum, res_id, busy, err});
        end
        repeat (2) tick();
        rst_n    = 1'b1;
        flushReq = 1'b0;
        tick();
    endtask

    task automatic test_single_requester();
        queueTxn(2, 10, 1, 3);
        waitResult("single", 200);
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_err got=%b required=0", err);
        end
    endtask

    task automatic test_contention();
        bit sawReady3;
        int n;
        applyReset();
        queueTxn(0, 10, 0, 0);
        queueTxn(3, 20, 0, 0);
        sawReady3 = 1'b0;
        n = 0;
        while (res_valid !== 1'b1 && n < 200) begin
            if (req_ready[3] !== 1'b0) sawReady3 = 1'b1;
            tick();
            n++;
        end
        checks++;
        if (sawReady3 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL contention_ready3 got=1 required=0 during first transaction");
        end
        waitResult("contention_first", 200);
        waitResult("contention_second", 200);
    endtask

    task automatic test_round_robin();
        applyReset();
        queueTxn(0, 5, 0, 0);
        queueTxn(1, 15, 0, 0);
        queueTxn(2, 25, 0, 0);
        queueTxn(3, 35, 0, 0);
        queueTxn(0, 45, 0, 0);
        for (int r = 0; r < 5; r++) begin
            waitResult($sformatf("round_robin_%0d", r), 200);
        end
    endtask

    task automatic test_backpressure();
        int n;
        int eid;
        int esum;
        bit stallBad;
        bit holdBad;
        logic [SW-1:0] heldSum;
        logic [1:0] heldId;
        res_ready = 1'b0;
        queueTxn(1, 40, 0, 0);
        n = 0;
        while (mCnt < 3 && n < 100) begin
            tick();
            n++;
        end
        tree_ready = 1'b0;
        stallBad   = 1'b0;
        repeat (5) begin
            tick();
            if (req_ready !== 4'b0000) stallBad = 1'b1;
        end
        tree_ready = 1'b1;
        checks++;
        if (stallBad) begin
            errors++;
            $display("[TB] FAIL backpressure_stall req_ready nonzero while tree_ready low, required 0000");
        end
        n = 0;
        while (res_valid !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        eid  = expId.pop_front();
        esum = expSum.pop_front();
        checks++;
        if (res_valid !== 1'b1 || res_id !== 2'(eid) || res_sum !== SW'(esum)) begin
            errors++;
            $display("[TB] FAIL backpressure_result got valid=%b id=%0d sum=%0d required valid=1 id=%0d sum=%0d",
                     res_valid, res_id, res_sum, eid, esum);
        end
        heldSum = res_sum;
        heldId  = res_id;
        holdBad = 1'b0;
        repeat (4) begin
            tick();
            if (res_valid !== 1'b1 || res_sum !== heldSum || res_id !== heldId) holdBad = 1'b1;
        end
        checks++;
        if (holdBad) begin
            errors++;
            $display("[TB] FAIL backpressure_hold got valid=%b id=%0d sum=%0d required valid=1 id=%0d sum=%0d",
                     res_valid, res_id, res_sum, heldId, heldSum);
        end
        res_ready = 1'b1;
        tick();
        checks++;
        if (res_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL backpressure_release res_valid got=%b required=0", res_valid);
        end
    endtask

    task automatic test_spurious();
        tick();
        spurSumValid = 1'b1;
        tick();
        spurSumValid = 1'b0;
        tick();
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("[TB] FAIL spurious_err got=%b required=1", err);
        end
        checks++;
        if (res_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL spurious_res_valid got=%b required=0", res_valid);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL spurious_busy got=%b required=0", busy);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        bit resSeen;
        queueTxn(1, 50, 0, 0);
        n = 0;
        while (mCnt < 4 && n < 100) begin
            tick();
            n++;
        end
        rst_n    = 1'b0;
        flushReq = 1'b1;
        void'(expId.pop_back());
        void'(expSum.pop_back());
        #1;
        checks++;
        if ({req_ready, tree_valid, tree_data, res_valid, res_sum, res_id, busy, err} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_mid_outputs got=%h required=0",
                     {req_ready, tree_valid, tree_data, res_valid, res_sum, res_id, busy, err});
        end
        resSeen = 1'b0;
        repeat (2) begin
            tick();
            if (res_valid !== 1'b0) resSeen = 1'b1;
        end
        rst_n    = 1'b1;
        flushReq = 1'b0;
        repeat (3) begin
            tick();
            if (res_valid !== 1'b0) resSeen = 1'b1;
        end
        checks++;
        if (resSeen) begin
            errors++;
            $display("[TB] FAIL reset_mid_abort res_valid got=1 required=0");
        end
        queueTxn(1, 30, 0, 1);
        waitResult("reset_mid_after", 200);
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_mid_err got=%b required=0", err);
        end
    endtask

    // Run every scenario in order, then report
    initial begin
        test_reset();
        test_single_requester();
        test_contention();
        test_round_robin();
        test_backpressure();
        test_spurious();
        test_reset_mid();
        checks++;
        if (expId.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_leftover got=%0d pending required=0", expId.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
